// File: rtl/ocram_arb2_pkg.sv
// Shared constants and types for the two-port on-chip RAM arbiter.
// Holds port encodings, the read-tag record and the hold-counter width helper.
package ocram_arb2_pkg;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // One stage of the read-ownership pipeline.
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/ocram_arb2_rr_lock.sv
// Two-way round-robin arbiter with burst lock bounded by a hold limit.
// Grant is purely combinational from req/lock and the registered last/lock/hold state.
module ocram_arb2_rr_lock
  import ocram_arb2_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);

  localparam int HW = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  logic          last_q, last_d;
  logic          lock_q, lock_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          keep;
  logic          win;
  logic          gnt_any;
  logic          gnt_port;

  // lock_q remembers whether last cycle's grantee asked to keep the bus.
  always_comb begin
    gnt_o = 2'b00;
    win   = PORT0;
    keep  = lock_q && req_i[last_q] && (hold_q < HOLD_LIM);
    if (req_i[0] && req_i[1]) begin
      win        = keep ? last_q : ~last_q;
      gnt_o[win] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

  always_comb begin
    gnt_any  = |gnt_o;
    gnt_port = gnt_o[1];
    last_d   = gnt_any ? gnt_port : last_q;
    lock_d   = gnt_any ? lock_i[gnt_port] : 1'b0;
    hold_d   = '0;
    if (gnt_any && (gnt_port == last_q) && lock_q && req_i[~gnt_port]) begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT1;
      lock_q <= 1'b0;
      hold_q <= '0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/ocram_arb2.sv
// Two-requester front end for a single-port on-chip RAM: arbitrates, registers the
// RAM command and steers 1-cycle-latency read data back to the requesting port.
module ocram_arb2
  import ocram_arb2_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 14,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [AWIDTH-1:0] m0_addr_i,
  input  logic [DWIDTH-1:0] m0_d_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DWIDTH-1:0] m0_q_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [AWIDTH-1:0] m1_addr_i,
  input  logic [DWIDTH-1:0] m1_d_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DWIDTH-1:0] m1_q_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [AWIDTH-1:0] ram_addr_o,
  output logic [DWIDTH-1:0] ram_d_o,
  input  logic [DWIDTH-1:0] ram_q_i
);

  logic [1:0]        gnt;
  logic              gnt_any;
  logic              sel_we;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_d;

  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] d_q, d_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q;
  logic [DWIDTH-1:0] q0_q, q1_q;
  logic              rvalid0, rvalid1;

  ocram_arb2_rr_lock #(
    .MAX_HOLD(MAX_HOLD)
  ) u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i ({m1_req_i, m0_req_i}),
    .lock_i({m1_lock_i, m0_lock_i}),
    .gnt_o (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  // Idle cycles drop ce but leave the rest of the command bus untouched.
  always_comb begin
    gnt_any  = |gnt;
    sel_we   = gnt[1] ? m1_we_i   : m0_we_i;
    sel_addr = gnt[1] ? m1_addr_i : m0_addr_i;
    sel_d    = gnt[1] ? m1_d_i    : m0_d_i;
    ce_d     = gnt_any;
    we_d     = gnt_any ? sel_we   : we_q;
    addr_d   = gnt_any ? sel_addr : addr_q;
    d_d      = gnt_any ? sel_d    : d_q;
    tag1_d   = '{valid: gnt_any && !sel_we, port: gnt[1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      d_q    <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      ce_q   <= ce_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      d_q    <= d_d;
      tag1_q <= tag1_d;
      tag2_q <= tag1_q;
    end
  end

  assign ram_ce_o   = ce_q;
  assign ram_we_o   = we_q;
  assign ram_addr_o = addr_q;
  assign ram_d_o    = d_q;

  // Stage 2 lines up with the cycle the RAM presents the read word.
  assign rvalid0 = tag2_q.valid && (tag2_q.port == PORT0);
  assign rvalid1 = tag2_q.valid && (tag2_q.port == PORT1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q0_q <= '0;
      q1_q <= '0;
    end else begin
      if (rvalid0) q0_q <= ram_q_i;
      if (rvalid1) q1_q <= ram_q_i;
    end
  end

  assign m0_rvalid_o = rvalid0;
  assign m1_rvalid_o = rvalid1;
  assign m0_q_o      = rvalid0 ? ram_q_i : q0_q;
  assign m1_q_o      = rvalid1 ? ram_q_i : q1_q;

endmodule

// File: tb/tb_ocram_arb2.sv
// Directed and randomized checks of ocram_arb2 against a behavioural RAM and a
// reference memory that predicts every read return per port.
module tb_ocram_arb2;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_d, m0_q;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_d, m1_q;
  logic          ram_ce, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d, ram_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  typedef struct packed {
    logic r0, l0, r1, l1, g0, g1;
  } vec_t;
  vec_t vecs [23];

  always #5 clk = ~clk;

  ocram_arb2 #(.DWIDTH(DW), .AWIDTH(AW), .MAX_HOLD(MH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock), .m0_addr_i(m0_addr),
    .m0_d_i(m0_d), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_q_o(m0_q),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr),
    .m1_d_i(m1_d), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_q_o(m1_q),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_d_o(ram_d),
    .ram_q_i(ram_q)
  );

  // Behavioural single-port RAM, 1-cycle read.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) ram_mem[ram_addr] <= ram_d;
      else        ram_q <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv0(input logic req, input logic we, input logic lock,
                      input logic [AW-1:0] addr, input logic [DW-1:0] d);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_d = d;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock,
                      input logic [AW-1:0] addr, input logic [DW-1:0] d);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_d = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: predict read data at grant time, compare on each rvalid.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (m0_rvalid) begin
        if (exp_q0.size() == 0) chk("rd0_spurious", 1, 0);
        else chk("rd0_data", m0_q, exp_q0.pop_front());
      end
      if (m1_rvalid) begin
        if (exp_q1.size() == 0) chk("rd1_spurious", 1, 0);
        else chk("rd1_data", m1_q, exp_q1.pop_front());
      end
      if (m0_gnt) begin
        if (m0_we) ref_mem[m0_addr] = m0_d;
        else exp_q0.push_back(ref_mem.exists(m0_addr) ? ref_mem[m0_addr] : '0);
      end
      if (m1_gnt) begin
        if (m1_we) ref_mem[m1_addr] = m1_d;
        else exp_q1.push_back(ref_mem.exists(m1_addr) ? ref_mem[m1_addr] : '0);
      end
    end
  end

  initial begin
    int i0, i1, gc, g0c, cec, rvc, run0, maxw, w0, w1;
    logic seen1, p0, p1, we0, we1, lk0, lk1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    //            r0    l0    r1    l1    g0    g1
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ce", ram_ce, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_d", ram_d, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_q", {m0_q, m1_q}, 0);
    next_cycle();
    rst_n = 1'b1;

    // Arbitration table (writes only)
    for (int i = 0; i < 23; i++) begin
      drv0(vecs[i].r0, 1'b1, vecs[i].l0, AW'(i), 32'h1000 + i);
      drv1(vecs[i].r1, 1'b1, vecs[i].l1, AW'(i + 64), 32'h2000 + i);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), {m0_gnt, m1_gnt}, {vecs[i].g0, vecs[i].g1});
      next_cycle();
    end
    idle();
    repeat (3) next_cycle();

    // Single port write then read of the same address
    drv0(1'b1, 1'b1, 1'b0, 14'h0010, 32'hDEADBEEF);
    @(negedge clk);
    chk("sp_wr_gnt", {m0_gnt, m1_gnt}, 2'b10);
    next_cycle();
    drv0(1'b1, 1'b0, 1'b0, 14'h0010, 32'h0);
    @(negedge clk);
    chk("sp_rd_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("sp_wr_cmd", {ram_ce, ram_we, ram_addr, ram_d}, {1'b1, 1'b1, 14'h0010, 32'hDEADBEEF});
    next_cycle();
    idle();
    @(negedge clk);
    chk("sp_rd_cmd", {ram_ce, ram_we, ram_addr}, {1'b1, 1'b0, 14'h0010});
    chk("sp_rvalid_early", m0_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("sp_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("sp_q", m0_q, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    chk("sp_rvalid_once", m0_rvalid, 0);
    chk("sp_q_hold", m0_q, 32'hDEADBEEF);
    chk("sp_idle_cmd", {ram_ce, ram_addr}, {1'b0, 14'h0010});
    next_cycle();

    // Preload, then contention on reads without lock
    for (int i = 0; i < 16; i++) begin
      drv0(1'b1, 1'b1, 1'b0, (i < 8) ? AW'(14'h100 + i) : AW'(14'h200 + i - 8),
           (i < 8) ? 32'hA000_0000 + i : 32'hB000_0000 + i - 8);
      next_cycle();
    end
    idle();
    next_cycle();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      drv0(1'b1, 1'b0, 1'b0, AW'(14'h100 + i0), '0);
      drv1(1'b1, 1'b0, 1'b0, AW'(14'h200 + i1), '0);
      @(negedge clk);
      chk($sformatf("cont%0d_gnt", k), {m0_gnt, m1_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (m0_gnt) i0++;
      if (m1_gnt) i1++;
      next_cycle();
    end
    idle();
    repeat (3) next_cycle();

    // Port 1 write burst with port 0 idle
    gc = 0; g0c = 0; cec = 0; rvc = 0;
    for (int k = 0; k < 14; k++) begin
      if (k < 10) drv1(1'b1, 1'b1, 1'b0, AW'(14'h300 + k), 32'hC000_0000 + k);
      else idle();
      @(negedge clk);
      if (m1_gnt && k < 10) gc++;
      if (m0_gnt) g0c++;
      if (ram_ce) cec++;
      if (m0_rvalid || m1_rvalid) rvc++;
      next_cycle();
    end
    chk("wr_burst_gnts", gc, 10);
    chk("wr_burst_m0_gnts", g0c, 0);
    chk("wr_burst_ce", cec, 10);
    chk("wr_burst_rvalid", rvc, 0);

    // Lock bound: port 0 locked, port 1 waiting
    run0 = 0; seen1 = 1'b0;
    for (int k = 0; k < 8 && !seen1; k++) begin
      drv0(1'b1, 1'b0, 1'b1, 14'h0100, '0);
      drv1(1'b1, 1'b0, 1'b0, 14'h0200, '0);
      @(negedge clk);
      if (m1_gnt) seen1 = 1'b1;
      else if (m0_gnt) run0++;
      next_cycle();
    end
    chk("lock_release", seen1, 1);
    chk("lock_run", run0, MH);
    idle();
    repeat (3) next_cycle();

    // Reset mid-traffic
    drv0(1'b1, 1'b0, 1'b0, 14'h0101, '0);
    drv1(1'b1, 1'b0, 1'b0, 14'h0201, '0);
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", {ram_ce, ram_we, ram_addr, ram_d}, 0);
    chk("mid_rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rvalid%0d", k), {m0_rvalid, m1_rvalid}, 0);
      next_cycle();
    end
    drv0(1'b1, 1'b0, 1'b0, 14'h0100, '0);
    drv1(1'b1, 1'b0, 1'b0, 14'h0200, '0);
    @(negedge clk);
    chk("post_rst_tie", {m0_gnt, m1_gnt}, 2'b10);
    next_cycle();
    idle();
    repeat (3) next_cycle();

    // Random traffic against the reference memory
    for (int i = 0; i < 32; i++) begin
      drv0(1'b1, 1'b1, 1'b0, AW'(i), $urandom);
      next_cycle();
    end
    idle();
    p0 = 0; p1 = 0; we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    w0 = 0; w1 = 0; maxw = 0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1; we0 = 1'($urandom_range(0, 1)); a0 = AW'($urandom_range(0, 31)); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1; we1 = 1'($urandom_range(0, 1)); a1 = AW'($urandom_range(0, 31)); d1 = $urandom;
      end
      lk0 = ($urandom_range(0, 3) == 0);
      lk1 = ($urandom_range(0, 3) == 0);
      drv0(p0, we0, lk0, a0, d0);
      drv1(p1, we1, lk1, a1, d1);
      @(negedge clk);
      chk("rand_gnt_legal", {m0_gnt & m1_gnt, m0_gnt & ~p0, m1_gnt & ~p1}, 0);
      chk("rand_no_bubble", m0_gnt | m1_gnt, p0 | p1);
      if (m0_gnt) begin p0 = 0; w0 = 0; end else if (p0) w0++;
      if (m1_gnt) begin p1 = 0; w1 = 0; end else if (p1) w1++;
      if (w0 > maxw) maxw = w0;
      if (w1 > maxw) maxw = w1;
      next_cycle();
    end
    chk("rand_max_wait_ok", maxw <= MH, 1);
    idle();
    repeat (4) next_cycle();
    chk("sb_drain0", exp_q0.size(), 0);
    chk("sb_drain1", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
